// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial subtractor, D = A - B - bin, LSB first
//
// One borrow cell and one borrow flip-flop process a single bit per clock.
// A start/busy/done handshake launches an operation and reports completion.
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   start   launch request, sampled only while idle
//   a       minuend, captured on an accepted start
//   b       subtrahend, captured on an accepted start
//   bin     borrow-in, captured on an accepted start
//   busy    high while bits are being shifted through the borrow cell
//   done    one-cycle pulse, d/bout/ovf hold the new result
//   d       difference modulo 2^WIDTH, held until the next result lands
//   bout    borrow-out, 1 when unsigned a < b + bin
//   ovf     two's-complement overflow of a - b - bin

module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] sa;       // remaining minuend bits, consumed from bit 0
    logic [WIDTH-1:0] sb;       // remaining subtrahend bits
    logic [WIDTH-1:0] res;      // difference bits enter at the MSB and move down
    logic             br;       // borrow into the bit being processed
    logic [CW-1:0]    cnt;      // index of the bit being processed

    logic             x, y;
    logic             dbit;
    logic             br_next;
    logic             last;

    // Full-subtractor cell.
    always_comb begin
        x       = sa[0];
        y       = sb[0];
        dbit    = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
        last    = (cnt == LAST);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d    <= '0;
            bout <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= bin;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    br  <= br_next;
                    res <= {dbit, res[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    // On the MSB cycle br is the borrow into the sign bit, so
                    // overflow is that borrow XOR the borrow leaving the MSB.
                    // Results are published as the FSM enters DONE.
                    if (last) begin
                        d    <= {dbit, res[WIDTH-1:1]};
                        bout <= br_next;
                        ovf  <= br ^ br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor

module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;

    int n_chk   = 0;
    int n_fail  = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int overlap  = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .bout   (bout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (busy && done) overlap++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic void model(input int ai, input int bi, input int bini,
                                  output logic [W-1:0] ed, output logic eb, output logic eo);
        int diff, sa_i, sb_i, sr;
        diff = ai - bi - bini;
        ed   = W'(diff & ((1 << W) - 1));
        eb   = (ai < bi + bini);
        sa_i = (ai >= (1 << (W - 1))) ? ai - (1 << W) : ai;
        sb_i = (bi >= (1 << (W - 1))) ? bi - (1 << W) : bi;
        sr   = sa_i - sb_i - bini;
        eo   = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    endfunction

    // Launch from IDLE, verify handshake timing and result, return in IDLE.
    task automatic run_op(input int ta, input int tb_v, input int tbin, input string tag);
        logic [W-1:0] ed;
        logic         eb, eo, seen;
        int           lat, nbusy;
        model(ta, tb_v, tbin, ed, eb, eo);
        a = W'(ta); b = W'(tb_v); bin = tbin[0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        seen = 1'b0; lat = 0; nbusy = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
                lat  = i;
            end else begin
                if (busy) nbusy++;
                @(posedge clk); #1;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_latency"}, lat, W + 1);
        chk({tag, "_busy_cycles"}, nbusy, W);
        chk({tag, "_d"}, d, ed);
        chk({tag, "_bout"}, bout, eb);
        chk({tag, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    initial begin : main
        int b0, d0, t1, t2, bad;
        logic seen;

        resetn = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_d", d, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        run_op(7, 3, 0, "tp_7m3");
        chk("tp_7m3_lit", {d, bout, ovf}, {4'h4, 1'b0, 1'b0});
        run_op(3, 9, 0, "tp_3m9");
        chk("tp_3m9_lit", {d, bout, ovf}, {4'hA, 1'b1, 1'b1});
        run_op(0, 0, 1, "tp_0m0b");
        chk("tp_0m0b_lit", {d, bout, ovf}, {4'hF, 1'b1, 1'b0});
        run_op(8, 1, 0, "tp_8m1");
        chk("tp_8m1_lit", {d, bout, ovf}, {4'h7, 1'b0, 1'b1});

        // start pulses during SHIFT and during DONE must be ignored
        b0 = busy_cnt; d0 = done_cnt;
        a = 4'd7; b = 4'd3; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 4'd1; b = 4'd1; bin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("ign_done_seen", seen, 1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ign_busy_total", busy_cnt - b0, W);
        chk("ign_done_total", done_cnt - d0, 1);
        chk("ign_d", d, 4'h4);
        chk("ign_bout", bout, 0);
        chk("ign_ovf", ovf, 0);

        // asynchronous reset in the second SHIFT cycle aborts the operation
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("arst_busy_before", busy, 1);
        d0 = done_cnt;
        resetn = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_d", d, 0);
        chk("arst_bout", bout, 0);
        chk("arst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_no_done", done_cnt - d0, 0);
        chk("arst_idle", busy, 0);
        run_op(5, 2, 1, "after_rst");

        // start held high across two operations
        t1 = -1; t2 = -1; bad = 0;
        a = 4'd3; b = 4'd9; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd8; b = 4'd1; bin = 1'b0;
        for (int i = 0; i < 40 && t2 < 0; i++) begin
            if (done) begin
                if (t1 < 0) begin
                    t1 = i;
                    chk("held_d1", {d, bout, ovf}, {4'hA, 1'b1, 1'b1});
                end else begin
                    t2 = i;
                    chk("held_d2", {d, bout, ovf}, {4'h7, 1'b0, 1'b1});
                end
            end else if (t1 >= 0 && d !== 4'hA) begin
                bad++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk("held_first_seen", t1 >= 0, 1);
        chk("held_spacing", t2 - t1, W + 2);
        chk("held_d_stable", bad, 0);
        @(posedge clk); #1;

        // exhaustive sweep
        for (int ia = 0; ia < (1 << W); ia++)
            for (int ib = 0; ib < (1 << W); ib++)
                for (int ic = 0; ic < 2; ic++)
                    run_op(ia, ib, ic, "sweep");

        // randomized operands with random idle gaps
        for (int k = 0; k < 100; k++) begin
            run_op(int'($urandom_range(0, (1 << W) - 1)), int'($urandom_range(0, (1 << W) - 1)),
                   int'($urandom_range(0, 1)), "rand");
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        chk("busy_done_overlap", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
